clic_arbiter: RTL



---
 rtl/clic_arb_pkg.sv | 49 ++++
 rtl/clic_arbiter_if.sv | 25 ++
 rtl/clic_arb_tree.sv | 49 ++++
 rtl/clic_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/clic_arb_pkg.sv
// Shared types and helpers for the CLIC interrupt arbiter: FSM states,
// candidate record and level derivation from clicintctl/nlbits.
package clic_arb_pkg;

    localparam int unsigned IntCtlW = 8;
    // Wide enough for up to 1024 sources; the top slices it to SRC_W
    localparam int unsigned IdW     = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_CLAIM,
        ST_KILL
    } arb_state_e;

    typedef struct packed {
        logic               valid;
        logic [IdW-1:0]     id;
        logic [IntCtlW-1:0] intctl;
        logic [IntCtlW-1:0] level;
        logic               shv;
    } arb_cand_t;

    // Keep the top nlbits bits of intctl and force the rest to 1
    function automatic logic [IntCtlW-1:0] clic_level(input logic [IntCtlW-1:0] intctl,
                                                      input logic [3:0]         nlbits);
        logic [3:0]         nl;
        logic [IntCtlW-1:0] low_mask;
        nl       = (nlbits > 4'd8) ? 4'd8 : nlbits;
        low_mask = 8'hFF >> nl;
        return (intctl & ~low_mask) | low_mask;
    endfunction

    // 'hi' always carries the higher source ids, so it wins ties
    function automatic arb_cand_t arb_pick(input arb_cand_t lo, input arb_cand_t hi);
        arb_cand_t res;
        if (!hi.valid) begin
            res = lo;
        end else if (!lo.valid) begin
            res = hi;
        end else if (hi.intctl >= lo.intctl) begin
            res = hi;
        end else begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/clic_arbiter_if.sv
// Core-side interrupt offer/claim/kill handshake of the CLIC arbiter.
interface clic_arbiter_if #(
    parameter int unsigned N_SOURCE = 32
);
    localparam int unsigned SRC_W = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;

    logic             irq_valid_o;
    logic             irq_ready_i;
    logic [SRC_W-1:0] irq_id_o;
    logic [7:0]       irq_level_o;
    logic             irq_shv_o;
    logic             kill_req_o;
    logic             kill_ack_i;

    modport master (
        output irq_valid_o, irq_id_o, irq_level_o, irq_shv_o, kill_req_o,
        input  irq_ready_i, kill_ack_i
    );

    modport slave (
        input  irq_valid_o, irq_id_o, irq_level_o, irq_shv_o, kill_req_o,
        output irq_ready_i, kill_ack_i
    );

endinterface

// File: rtl/clic_arb_tree.sv
// Combinational max-intctl compare tree over all sources; ties go to the
// higher id and leaves beyond N_SOURCE are padded as ineligible.
module clic_arb_tree
    import clic_arb_pkg::*;
#(
    parameter int unsigned N_SOURCE   = 32,
    parameter int unsigned INTCTLBITS = 8
) (
    input  logic [N_SOURCE-1:0]        ip_i,
    input  logic [N_SOURCE-1:0]        ie_i,
    input  logic [N_SOURCE-1:0]        shv_i,
    input  logic [N_SOURCE-1:0][7:0]   intctl_i,
    input  logic [3:0]                 nlbits_i,
    input  logic [7:0]                 mintthresh_i,
    output arb_cand_t                  best_o
);

    localparam int unsigned LEAF_W = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;
    localparam int unsigned N_LEAF = 1 << LEAF_W;
    localparam int unsigned N_NODE = 2 * N_LEAF - 1;
    // Unimplemented low clicintctl bits read as 1
    localparam logic [7:0]  CTL_PAD = 8'((1 << (8 - INTCTLBITS)) - 1);

    arb_cand_t node [N_NODE];

    // Heap layout: leaves at N_LEAF-1.., children of k at 2k+1 / 2k+2
    always_comb begin
        for (int unsigned i = 0; i < N_NODE; i++) begin
            node[i] = '0;
        end
        for (int unsigned i = 0; i < N_SOURCE; i++) begin
            logic [7:0] ctl;
            logic [7:0] lvl;
            ctl = intctl_i[i] | CTL_PAD;
            lvl = clic_level(ctl, nlbits_i);
            node[N_LEAF-1+i].valid  = ip_i[i] & ie_i[i] & (lvl > mintthresh_i);
            node[N_LEAF-1+i].id     = IdW'(i);
            node[N_LEAF-1+i].intctl = ctl;
            node[N_LEAF-1+i].level  = lvl;
            node[N_LEAF-1+i].shv    = shv_i[i];
        end
        for (int unsigned k = 0; k < N_LEAF - 1; k++) begin
            node[N_LEAF-2-k] = arb_pick(node[2*(N_LEAF-2-k)+1], node[2*(N_LEAF-2-k)+2]);
        end
    end

    assign best_o = node[0];

endmodule

// File: rtl/clic_arbiter.sv
// CLIC interrupt selection and delivery: registered compare tree feeding an
// offer/claim FSM. Optional stale-offer retraction under CLIC_ARB_KILL_EN.
module clic_arbiter
    import clic_arb_pkg::*;
#(
    parameter int unsigned N_SOURCE   = 32,
    parameter int unsigned INTCTLBITS = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_SOURCE-1:0]       ip_i,
    input  logic [N_SOURCE-1:0]       ie_i,
    input  logic [N_SOURCE-1:0]       le_i,
    input  logic [N_SOURCE-1:0]       shv_i,
    input  logic [N_SOURCE-1:0][7:0]  intctl_i,
    input  logic [3:0]                nlbits_i,
    input  logic [7:0]                mintthresh_i,
    clic_arbiter_if.master            irq,
    output logic [N_SOURCE-1:0]       clr_edge_o
);

    localparam int unsigned SRC_W = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;

    arb_cand_t           tree_best;
    arb_cand_t           best_q, best_d;
    arb_cand_t           offer_q, offer_d;
    arb_state_e          state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [SRC_W-1:0]    offer_id;
    logic [N_SOURCE-1:0] clr_edge;
    logic                kill_cond;

    clic_arb_tree #(
        .N_SOURCE   (N_SOURCE),
        .INTCTLBITS (INTCTLBITS)
    ) u_tree (
        .ip_i         (ip_i),
        .ie_i         (ie_i),
        .shv_i        (shv_i),
        .intctl_i     (intctl_i),
        .nlbits_i     (nlbits_i),
        .mintthresh_i (mintthresh_i),
        .best_o       (tree_best)
    );

    assign offer_id = offer_q.id[SRC_W-1:0];

`ifdef CLIC_ARB_KILL_EN
    // Retract when something better is waiting or the offer went stale
    always_comb begin
        kill_cond = (best_q.valid && (best_q.intctl > offer_q.intctl)) ||
                    !(ip_i[offer_id] && ie_i[offer_id]) ||
                    (offer_q.level <= mintthresh_i);
    end
    assign irq.kill_req_o = (state_q == ST_KILL);
`else
    logic unused_kill_ack;
    assign unused_kill_ack = irq.kill_ack_i;
    assign kill_cond       = 1'b0;
    assign irq.kill_req_o  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        offer_d  = offer_q;
        cnt_d    = cnt_q;
        best_d   = tree_best;
        clr_edge = '0;
        case (state_q)
            ST_IDLE: begin
                if (best_q.valid) begin
                    offer_d = best_q;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // Claim takes priority over a simultaneous kill condition
                if (irq.irq_ready_i) begin
                    clr_edge[offer_id] = le_i[offer_id] & ~rst_i;
                    cnt_d              = '0;
                    state_d            = ST_CLAIM;
                end else if (kill_cond) begin
                    state_d = ST_KILL;
                end
            end
            ST_CLAIM: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef CLIC_ARB_KILL_EN
            ST_KILL: begin
                if (irq.kill_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            best_q  <= '0;
            offer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            best_q  <= best_d;
            offer_q <= offer_d;
            cnt_q   <= cnt_d;
        end
    end

    assign irq.irq_valid_o = (state_q == ST_OFFER);
    assign irq.irq_id_o    = offer_id;
    assign irq.irq_level_o = offer_q.level;
    assign irq.irq_shv_o   = offer_q.shv;
    assign clr_edge_o      = clr_edge;

endmodule
